// File: rtl/regfile_sb.sv
// Parametrised 2-read / 1-write register file with a per-register busy scoreboard.
// Reads and hazard flags are combinational; writes and scoreboard updates happen at posedge.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            busy1,
   output logic            busy2,
   output logic            hazard
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   logic wr_en_s;
   logic iss_en_s;
   logic byp1_s;
   logic byp2_s;
   logic fwd1_s;
   logic fwd2_s;

   function automatic logic is_zero(input logic [AW-1:0] idx);
      return (ZERO_REG != 0) && (idx == {AW{1'b0}});
   endfunction

   assign wr_en_s  = we && !is_zero(rd);
   assign iss_en_s = issue_valid && !is_zero(issue_rd);

   // fwd*: a writeback to the read index this cycle (used to hide the completing producer)
   assign fwd1_s = (BYPASS != 0) && we && (rd == rs1);
   assign fwd2_s = (BYPASS != 0) && we && (rd == rs2);
   assign byp1_s = fwd1_s && rst_n;
   assign byp2_s = fwd2_s && rst_n;

   // Next-state for register contents and busy bits; the set is applied last so it wins
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      regs_d[rd] = wr_en_s ? wdata : regs_q[rd];
      busy_d[rd] = wr_en_s ? 1'b0 : busy_q[rd];
      busy_d[issue_rd] = iss_en_s ? 1'b1 : busy_d[issue_rd];
   end

   // State update with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= {XLEN{1'b0}};
         end
         busy_q <= {NREGS{1'b0}};
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Read ports: zero register, then write-first forwarding, then stored value
   always_comb begin
      if (is_zero(rs1)) begin
         rdata1 = {XLEN{1'b0}};
      end else if (byp1_s) begin
         rdata1 = wdata;
      end else begin
         rdata1 = regs_q[rs1];
      end
      if (is_zero(rs2)) begin
         rdata2 = {XLEN{1'b0}};
      end else if (byp2_s) begin
         rdata2 = wdata;
      end else begin
         rdata2 = regs_q[rs2];
      end
   end

   assign busy1  = busy_q[rs1] && !is_zero(rs1) && !fwd1_s;
   assign busy2  = busy_q[rs2] && !is_zero(rs2) && !fwd2_s;
   assign hazard = busy1 | busy2;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: instance A (32b x 32, bypass, zero reg) and
// instance B (64b x 16, no bypass, ordinary reg 0) run the same directed suite.
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst_n, a_we, a_iv;
   logic [4:0]  a_rd, a_rs1, a_rs2, a_ird;
   logic [31:0] a_wdata, a_rdata1, a_rdata2;
   logic        a_busy1, a_busy2, a_hazard;

   logic        b_rst_n, b_we, b_iv;
   logic [3:0]  b_rd, b_rs1, b_rs2, b_ird;
   logic [63:0] b_wdata, b_rdata1, b_rdata2;
   logic        b_busy1, b_busy2, b_hazard;

   regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1), .ZERO_REG(1)) u_a (
      .clk(clk), .rst_n(a_rst_n), .we(a_we), .rd(a_rd), .wdata(a_wdata),
      .rs1(a_rs1), .rs2(a_rs2), .rdata1(a_rdata1), .rdata2(a_rdata2),
      .issue_valid(a_iv), .issue_rd(a_ird),
      .busy1(a_busy1), .busy2(a_busy2), .hazard(a_hazard));

   regfile_sb #(.XLEN(64), .NREGS(16), .BYPASS(0), .ZERO_REG(0)) u_b (
      .clk(clk), .rst_n(b_rst_n), .we(b_we), .rd(b_rd), .wdata(b_wdata),
      .rs1(b_rs1), .rs2(b_rs2), .rdata1(b_rdata1), .rdata2(b_rdata2),
      .issue_valid(b_iv), .issue_rd(b_ird),
      .busy1(b_busy1), .busy2(b_busy2), .hazard(b_hazard));

   typedef struct {
      bit          sel;
      logic [63:0] d1;
      logic [63:0] d2;
      logic        b1;
      logic        b2;
      logic        hz;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic cmp(input string nm, input string fld, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s %s: got %h expected %h", nm, fld, got, want);
      end
   endtask

   // Monitor: outputs are combinational, so each cycle with a queued entry is checked mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [63:0] g1, g2;
         logic gb1, gb2, ghz;
         e = exp_q.pop_front();
         if (e.sel) begin
            g1 = b_rdata1; g2 = b_rdata2; gb1 = b_busy1; gb2 = b_busy2; ghz = b_hazard;
         end else begin
            g1 = {32'h0, a_rdata1}; g2 = {32'h0, a_rdata2};
            gb1 = a_busy1; gb2 = a_busy2; ghz = a_hazard;
         end
         cmp(e.name, "rdata1", g1, e.d1);
         cmp(e.name, "rdata2", g2, e.d2);
         cmp(e.name, "busy1", {63'h0, gb1}, {63'h0, e.b1});
         cmp(e.name, "busy2", {63'h0, gb2}, {63'h0, e.b2});
         cmp(e.name, "hazard", {63'h0, ghz}, {63'h0, e.hz});
      end
   end

   task automatic idle_all();
      a_rst_n = 1'b1; a_we = 1'b0; a_iv = 1'b0; a_rd = 5'd0; a_rs1 = 5'd0;
      a_rs2 = 5'd0; a_ird = 5'd0; a_wdata = 32'h0;
      b_rst_n = 1'b1; b_we = 1'b0; b_iv = 1'b0; b_rd = 4'd0; b_rs1 = 4'd0;
      b_rs2 = 4'd0; b_ird = 4'd0; b_wdata = 64'h0;
   endtask

   // One clock of stimulus on the selected instance; optionally queues the expected response
   task automatic cyc(input bit s, input logic rst_v, input logic we_v, input logic [4:0] rd_v,
                      input logic [63:0] wd_v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic iv_v, input logic [4:0] ird_v, input bit chk,
                      input logic [63:0] e1, input logic [63:0] e2,
                      input logic eb1, input logic eb2, input string nm);
      exp_t e;
      idle_all();
      if (s) begin
         b_rst_n = rst_v; b_we = we_v; b_rd = rd_v[3:0]; b_wdata = wd_v;
         b_rs1 = r1[3:0]; b_rs2 = r2[3:0]; b_iv = iv_v; b_ird = ird_v[3:0];
      end else begin
         a_rst_n = rst_v; a_we = we_v; a_rd = rd_v; a_wdata = wd_v[31:0];
         a_rs1 = r1; a_rs2 = r2; a_iv = iv_v; a_ird = ird_v;
      end
      if (chk) begin
         e.sel  = s;
         e.d1   = s ? e1 : (e1 & 64'h0000_0000_FFFF_FFFF);
         e.d2   = s ? e2 : (e2 & 64'h0000_0000_FFFF_FFFF);
         e.b1   = eb1;
         e.b2   = eb2;
         e.hz   = eb1 | eb2;
         e.name = {s ? "B_" : "A_", nm};
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // s=0: BYPASS=1, ZERO_REG=1, 32 regs; s=1: BYPASS=0, ZERO_REG=0, 16 regs
   task automatic suite(input bit s);
      int n;
      n = s ? 16 : 32;
      cyc(s, 1'b0, 1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd5, 1'b1, 5'd4, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, "rst");
      for (int i = 0; i < n; i++) begin
         logic [4:0] i1, i2;
         i1 = 5'(i);
         i2 = 5'(n - 1 - i);
         cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, i1, i2, 1'b0, 5'd0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, "reset_read");
      end
      cyc(s, 1'b1, 1'b1, 5'd5, 64'hDEADBEEF, 5'd5, 5'd6, 1'b0, 5'd0, 1'b1,
          s ? 64'h0 : 64'hDEADBEEF, 64'h0, 1'b0, 1'b0, "wr5_same_cycle");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b1,
          64'hDEADBEEF, 64'hDEADBEEF, 1'b0, 1'b0, "rd5");
      cyc(s, 1'b1, 1'b1, 5'd7, 64'h12345678, 5'd7, 5'd7, 1'b0, 5'd0, 1'b1,
          s ? 64'h0 : 64'h12345678, s ? 64'h0 : 64'h12345678, 1'b0, 1'b0, "wr7_both_ports");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b1,
          64'h12345678, 64'h12345678, 1'b0, 1'b0, "rd7");
      cyc(s, 1'b1, 1'b1, 5'd0, 64'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1,
          64'h0, 64'h0, 1'b0, 1'b0, "zero_wr_issue");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1,
          s ? 64'hFFFFFFFF : 64'h0, s ? 64'hFFFFFFFF : 64'h0, s, s, "zero_rd");
      cyc(s, 1'b1, 1'b1, 5'd0, 64'h11, 5'd0, 5'd5, 1'b0, 5'd0, 1'b1,
          s ? 64'hFFFFFFFF : 64'h0, 64'hDEADBEEF, s, 1'b0, "zero_wb");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd5, 1'b0, 5'd0, 1'b1,
          s ? 64'h11 : 64'h0, 64'hDEADBEEF, 1'b0, 1'b0, "zero_after_wb");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1,
          s ? 64'h11 : 64'h0, 64'h0, 1'b0, 1'b0, "issue3");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd3, 1'b0, 5'd0, 1'b1,
          64'h0, 64'h0, 1'b0, 1'b1, "busy3");
      cyc(s, 1'b1, 1'b1, 5'd3, 64'h33, 5'd1, 5'd3, 1'b0, 5'd0, 1'b1,
          64'h0, s ? 64'h0 : 64'h33, 1'b0, s, "wb3");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd3, 1'b0, 5'd0, 1'b1,
          64'h0, 64'h33, 1'b0, 1'b0, "after_wb3");
      cyc(s, 1'b1, 1'b1, 5'd9, 64'h99, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1,
          s ? 64'h0 : 64'h99, 64'h33, 1'b0, 1'b0, "issue_wb9");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd9, 5'd3, 1'b0, 5'd0, 1'b1,
          64'h99, 64'h33, 1'b1, 1'b0, "set_wins9");
      cyc(s, 1'b1, 1'b1, 5'd9, 64'h98, 5'd9, 5'd9, 1'b0, 5'd0, 1'b1,
          s ? 64'h99 : 64'h98, s ? 64'h99 : 64'h98, s, s, "clear9");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b1,
          64'h98, 64'h98, 1'b0, 1'b0, "after_clear9");
      cyc(s, 1'b1, 1'b1, 5'd10, 64'hA5A55A5A01234567, 5'd10, 5'd9, 1'b0, 5'd0, 1'b1,
          s ? 64'h0 : 64'hA5A55A5A01234567, 64'h98, 1'b0, 1'b0, "wr10_wide");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd10, 5'd9, 1'b0, 5'd0, 1'b1,
          64'hA5A55A5A01234567, 64'h98, 1'b0, 1'b0, "rd10_wide");
      for (int i = 1; i <= 4; i++) begin
         cyc(s, 1'b1, 1'b1, 5'(i), 64'h100 + 64'(i), 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
             64'h0, 64'h0, 1'b0, 1'b0, "populate");
      end
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, "iss2");
      cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, 5'd2, 5'd4, 1'b0, 5'd0, 1'b1,
          64'h102, 64'h104, 1'b1, 1'b0, "pre_rst_busy2");
      cyc(s, 1'b0, 1'b1, 5'd1, 64'hFF, 5'd2, 5'd2, 1'b1, 5'd4, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, "mid_rst");
      for (int i = 0; i < n; i++) begin
         logic [4:0] i1, i2;
         i1 = 5'(i);
         i2 = 5'((i + 1) % n);
         cyc(s, 1'b1, 1'b0, 5'd0, 64'h0, i1, i2, 1'b0, 5'd0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, "post_rst_read");
      end
   endtask

   initial begin
      idle_all();
      @(posedge clk);
      #1;
      suite(1'b0);
      suite(1'b1);
      repeat (2) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's single-cycle register file: configurable data width, register count and write-to-read bypass, 2 async read / 1 sync write ports.
- Adds a per-register busy scoreboard: issue marks a destination pending, writeback clears it, read-side hazard flags drive the pipeline stall logic.
- Sits between decode (read + issue) and writeback in the 5-stage pipeline.

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of architectural registers; power of two, >= 2.
AW, $clog2(NREGS), index width; derived localparam, not overridden.
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only.
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes/issues to it ignored); 0 = register 0 is ordinary.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
we  input  1  writeback enable.
rd  input  AW  writeback register index.
wdata  input  XLEN  writeback data.
rs1  input  AW  read port 1 index.
rs2  input  AW  read port 2 index.
rdata1  output  XLEN  read port 1 data (combinational).
rdata2  output  XLEN  read port 2 data (combinational).
issue_valid  input  1  instruction with destination issued this cycle.
issue_rd  input  AW  destination index of the issued instruction.
busy1  output  1  rs1 has an outstanding producer (combinational).
busy2  output  1  rs2 has an outstanding producer (combinational).
hazard  output  1  busy1 | busy2.

Behaviour:
- Reset: clock and reset are fixed as a single clock and a synchronous active-low reset, so the reset is sampled only at the rising edge of clk. At the first posedge with rst_n=0, all NREGS registers are set to 0 and all busy bits are cleared.
- During reset: writes and issues are ignored; bypass is suppressed. After that first reset edge, rdata1/rdata2 read 0 and busy1/busy2/hazard read 0.
- Zero register: define z(i) = ZERO_REG && i==0. z(i) reads always return 0 and z(i) is never busy.
- Write: at posedge, if rst_n && we && !z(rd), regs[rd] <= wdata. Single-cycle latency; no other register is changed.
- Read port k (k=1,2, index rsk):
  - If z(rsk), returns 0.
  - Else if BYPASS && rst_n && we && rd==rsk, returns wdata (write-first).
  - Else returns regs[rsk].
- Both ports may name the same index; both then return identical data.
- Scoreboard: one busy bit per register, updated at posedge when rst_n=1.
  - Set condition: issue_valid && !z(issue_rd) sets busy[issue_rd].
  - Clear condition: we && !z(rd) clears busy[rd].
  - Same register set and cleared in one cycle: set wins (new producer supersedes the completing one). Different registers are updated independently.
  - Writeback to a non-busy register is legal; the bit stays 0.
- busyk = busy[rsk] && !z(rsk) && !(BYPASS && we && rd==rsk). With BYPASS, a register completing this cycle is not a hazard. With BYPASS=0, the stall holds until the cycle after writeback.
- hazard = busy1 | busy2. No registered outputs; all read-side outputs are combinational from inputs and state.
- Reset mid-operation: pending busy bits and register contents are discarded at that edge; any simultaneous we/issue is ignored.

Test Plan:
- Reset, then read all indices -> every rdata = 0, hazard = 0; write rd=5 data 0xDEADBEEF, next cycle rs1=5 -> rdata1 = 0xDEADBEEF.
- we=1, rd=7, wdata=0x12345678, rs1=rs2=7 in the same cycle -> both rdata = 0x12345678 with BYPASS=1; old value with BYPASS=0.
- Write 0xFFFFFFFF to rd=0 and issue_rd=0, then read rs1=0 -> rdata1 = 0, busy1 = 0 (ZERO_REG=1); with ZERO_REG=0 -> 0xFFFFFFFF and busy.
- issue rd=3; next cycle rs2=3 -> busy2 = 1, hazard = 1; writeback rd=3 -> busy2 = 0 in that cycle (BYPASS=1), then 0 thereafter.
- Issue rd=9 and writeback rd=9 in the same cycle -> busy[9] = 1 afterwards; a later writeback clears it.
- Populate regs 1..4 and set busy on 2, then assert rst_n=0 for one edge -> all reads 0, hazard 0; repeat the suite with XLEN=64, NREGS=16.
